upf_ret_bank_ctrl: RTL
======================

// Module: upf_ret_bank_ctrl
// PURPOSE
//  Synthesisable, parametrised retention register bank with an on-chip power-sequencing FSM.
//  Holds NCH channels of WIDTH-bit state registers plus shadow (retention) copies.
//  Sequences isolate -> save -> switch-off -> switch-on -> restore -> de-isolate.
//  Sits between the power-management controller and one switchable domain in the ALU testbench.
// PARAMETERS
//  WIDTH       8    bits per channel
//  NCH         4    channel count; save proceeds one channel per cycle
//  TO_CYC      16   max cycles waiting for PWR to change before ERR is flagged
//  CORRUPT_VAL 0    value of a main register after power loss (per bit, replicated)
//  ISO_VAL     0    clamp value on Q while ISO=1
// PORTS
//  CLK        in   1           clock
//  RESET_N    in   1           asynchronous active-low reset
//  PWR_REQ    in   1           1 = request domain power-down, 0 = request power-up
//  PWR        in   1           power-good from switch (1 = domain powered)
//  D          in   NCH*WIDTH   write data, channel c at [c*WIDTH +: WIDTH]
//  WE         in   NCH         per-channel write enable
//  Q          out  NCH*WIDTH   main register contents, clamped while isolated
//  PSW_EN     out  1           power-switch enable (1 = switch on)
//  ISO        out  1           isolation enable
//  RET        out  1           retention hold (1 while shadow owns the state)
//  BUSY       out  1           1 in every state except ON
//  RET_VALID  out  1           shadow holds a complete, consistent save
//  ERR        out  1           sticky: unexpected power loss or PWR timeout
// BEHAVIOUR
//  Reset (async, RESET_N=0): state=ON, main regs=0, PSW_EN=1, ISO=0, RET=0, BUSY=0,
//   RET_VALID=0, ERR=0, counters=0. Shadow regs are NOT reset (retention survives reset).
//  States: ON, ISO_ON, SAVE, OFF_WAIT, OFF, ON_WAIT, RESTORE, ISO_OFF, LOST.
//  ON: WE[c]=1 loads D channel c into main reg c at the next edge. PWR_REQ=1 -> ISO_ON.
//  ISO_ON: 1 cycle, ISO=1 -> SAVE. WE is ignored in every state except ON.
//  SAVE: channel index k=0..NCH-1, shadow[k]<=main[k], 1 channel/cycle, NCH cycles total.
//   After k=NCH-1: RET_VALID=1. If PWR_REQ is still 1 -> RET=1, PSW_EN=0, OFF_WAIT.
//   If PWR_REQ is 0 (abort) -> ISO_OFF; main regs stay intact, RET stays 0.
//  OFF_WAIT: wait for PWR=0 -> OFF (main regs <= CORRUPT_VAL). Timeout after TO_CYC -> ERR=1, OFF.
//  OFF: PWR_REQ=0 -> PSW_EN=1, ON_WAIT.
//  ON_WAIT: wait for PWR=1 -> RESTORE. Timeout after TO_CYC -> ERR=1, stay (PSW_EN held 1).
//  RESTORE: 1 cycle; all main[c]<=shadow[c] in parallel, RET=0 -> ISO_OFF.
//  ISO_OFF: 1 cycle, ISO=0 -> ON. Request-to-ON latency excludes PWR wait time:
//   down 1+NCH cycles to OFF_WAIT; up 2 cycles after PWR rises.
//  Unexpected PWR=0 in ON/ISO_ON/SAVE: main<=CORRUPT_VAL, ERR=1, RET_VALID=0 (partial save
//   discarded), PSW_EN=0 -> LOST. LOST: when PWR_REQ=0, PSW_EN=1; when PWR=1 -> ISO_OFF (no restore).
//  Q = ISO ? {NCH*WIDTH{ISO_VAL}} : main. Q changes only on CLK edges or reset.
//  Timeout counter width = clog2(TO_CYC+1). It clears on every state change and saturates.
//  ERR is cleared only by reset. RET_VALID clears on the next ON-state write to any channel.
// STRUCTURE
//  Package upf_ret_pkg: state enum ret_state_t, state encoding constants, clog2 function.
//  Sub-module upf_ret_chan: one channel, main + shadow reg with save/restore/corrupt/write
//   controls. Instantiated NCH times by generate. The FSM and counters stay in the top.
// TESTING
//  1 Write ch0..3 = 8'hA1,B2,C3,D4; full down/up cycle. Q returns A1..D4, RET_VALID=1, ERR=0,
//    and ISO spans the whole sequence.
//  2 Set PWR_REQ=1 and then PWR_REQ=0 during SAVE k=1. Save finishes, PSW_EN never drops,
//    and the block is back in ON with intact Q after NCH+2 cycles.
//  3 Drop PWR=0 in ON. Q=0 (CORRUPT_VAL), ERR=1, RET_VALID=0. Restore power: Q stays 0,
//    and no restore occurs.
//  4 Hold PWR=1 after PSW_EN=0. ERR=1 after 16 cycles, and the state reaches OFF.
//  5 Pulse RESET_N low while in OFF. State=ON, PSW_EN=1, ISO=0, Q=0, and shadow keeps its
//    saved values (checked via hierarchy).
//  6 Assert WE during ISO_ON/SAVE/OFF. Main regs are unchanged and the saved data matches
//    the pre-request values.

Source files
------------

// File: rtl/upf_ret_pkg.sv
// Shared definitions for the retention register bank: state encodings,
// the matching state enum, and a constant-evaluable ceil(log2) helper.
package upf_ret_pkg;

  localparam int STW = 4;

  localparam logic [STW-1:0] ST_ON       = 4'd0;
  localparam logic [STW-1:0] ST_ISO_ON   = 4'd1;
  localparam logic [STW-1:0] ST_SAVE     = 4'd2;
  localparam logic [STW-1:0] ST_OFF_WAIT = 4'd3;
  localparam logic [STW-1:0] ST_OFF      = 4'd4;
  localparam logic [STW-1:0] ST_ON_WAIT  = 4'd5;
  localparam logic [STW-1:0] ST_RESTORE  = 4'd6;
  localparam logic [STW-1:0] ST_ISO_OFF  = 4'd7;
  localparam logic [STW-1:0] ST_LOST     = 4'd8;

  typedef enum logic [STW-1:0] {
    RS_ON       = 4'd0,
    RS_ISO_ON   = 4'd1,
    RS_SAVE     = 4'd2,
    RS_OFF_WAIT = 4'd3,
    RS_OFF      = 4'd4,
    RS_ON_WAIT  = 4'd5,
    RS_RESTORE  = 4'd6,
    RS_ISO_OFF  = 4'd7,
    RS_LOST     = 4'd8
  } ret_state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/upf_ret_bank_ctrl_if.sv
// Bus between the power-management controller (master) and the retention
// bank (slave): power request/status, write port and bank status outputs.
interface upf_ret_bank_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  logic                   pwr_req;
  logic                   pwr;
  logic [NCH*WIDTH-1:0]   d;
  logic [NCH-1:0]         we;
  logic [NCH*WIDTH-1:0]   q;
  logic                   psw_en;
  logic                   iso;
  logic                   ret;
  logic                   busy;
  logic                   ret_valid;
  logic                   err;

  modport master (
    output pwr_req, pwr, d, we,
    input  q, psw_en, iso, ret, busy, ret_valid, err
  );

  modport slave (
    input  pwr_req, pwr, d, we,
    output q, psw_en, iso, ret, busy, ret_valid, err
  );
endinterface

// File: rtl/upf_ret_chan.sv
// One retention channel: a main register living in the switchable domain and
// a shadow copy that keeps its contents through power-off and through reset.
module upf_ret_chan #(
  parameter int WIDTH       = 8,
  parameter bit CORRUPT_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             save,
  input  logic             restore,
  input  logic             corrupt,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] main
);

  logic [WIDTH-1:0] shadow;

  // Main register: power loss beats restore, restore beats a normal write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      main <= '0;
    else if (corrupt)
      main <= {WIDTH{CORRUPT_VAL}};
    else if (restore)
      main <= shadow;
    else if (wr)
      main <= d;
  end

  // Shadow register is deliberately left out of reset so a save survives it.
  always_ff @(posedge clk) begin
    if (save)
      shadow <= main;
  end

endmodule

// File: rtl/upf_ret_bank_ctrl.sv
// Retention register bank with power-sequencing FSM:
// isolate -> save (one channel per cycle) -> switch off -> switch on ->
// restore -> de-isolate, plus detection of unexpected power loss and timeouts.
module upf_ret_bank_ctrl
  import upf_ret_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int TO_CYC      = 16,
  parameter bit CORRUPT_VAL = 1'b0,
  parameter bit ISO_VAL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  upf_ret_bank_ctrl_if.slave bus
);

  localparam int CW = clog2(TO_CYC + 1);
  localparam int KW = (NCH > 1) ? clog2(NCH) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] TO_SAT  = CW'(TO_CYC);
  localparam logic [KW-1:0] K_LAST  = KW'(NCH - 1);

  logic [STW-1:0]   state;
  logic [STW-1:0]   nxt;
  logic [CW-1:0]    cnt;
  logic [KW-1:0]    k;
  logic             psw_en;
  logic             iso;
  logic             ret;
  logic             ret_valid;
  logic             err;

  logic             pwr_lost;
  logic             corrupt_all;
  logic             restore_all;
  logic [NCH-1:0]   wr_en;
  logic [NCH-1:0]   save_en;
  logic [WIDTH-1:0] main_q [NCH];

  // Channel control strobes derived from the current state and inputs.
  always_comb begin
    pwr_lost    = !bus.pwr &&
                  ((state == ST_ON) || (state == ST_ISO_ON) || (state == ST_SAVE));
    corrupt_all = pwr_lost ||
                  ((state == ST_OFF_WAIT) && (!bus.pwr || (cnt == TO_LAST)));
    restore_all = (state == ST_RESTORE);
    wr_en       = ((state == ST_ON) && !pwr_lost) ? bus.we : '0;
    save_en     = '0;
    if ((state == ST_SAVE) && !pwr_lost)
      save_en[k] = 1'b1;
  end

  // Next-state decode for the power sequencer.
  always_comb begin
    nxt = state;
    case (state)
      ST_ON:       if (!bus.pwr) nxt = ST_LOST;
                   else if (bus.pwr_req) nxt = ST_ISO_ON;
      ST_ISO_ON:   nxt = !bus.pwr ? ST_LOST : ST_SAVE;
      ST_SAVE:     if (!bus.pwr) nxt = ST_LOST;
                   else if (k == K_LAST) nxt = bus.pwr_req ? ST_OFF_WAIT : ST_ISO_OFF;
      ST_OFF_WAIT: if (!bus.pwr || (cnt == TO_LAST)) nxt = ST_OFF;
      ST_OFF:      if (!bus.pwr_req) nxt = ST_ON_WAIT;
      ST_ON_WAIT:  if (bus.pwr) nxt = ST_RESTORE;
      ST_RESTORE:  nxt = ST_ISO_OFF;
      ST_ISO_OFF:  nxt = ST_ON;
      ST_LOST:     if (bus.pwr) nxt = ST_ISO_OFF;
      default:     nxt = ST_ON;
    endcase
  end

  // State, save index and the saturating per-state timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ON;
      cnt   <= '0;
      k     <= '0;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= '0;
      else if (cnt != TO_SAT)
        cnt <= cnt + CW'(1);
      if ((state == ST_SAVE) && (nxt == ST_SAVE))
        k <= k + KW'(1);
      else
        k <= '0;
    end
  end

  // Power-switch, isolation, retention and status flags updated on transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw_en    <= 1'b1;
      iso       <= 1'b0;
      ret       <= 1'b0;
      ret_valid <= 1'b0;
      err       <= 1'b0;
    end else if (pwr_lost) begin
      psw_en    <= 1'b0;
      iso       <= 1'b1;
      ret_valid <= 1'b0;
      err       <= 1'b1;
    end else begin
      case (state)
        ST_ON: begin
          if (|bus.we) ret_valid <= 1'b0;
          if (bus.pwr_req) iso <= 1'b1;
        end
        ST_SAVE: begin
          if (k == K_LAST) begin
            ret_valid <= 1'b1;
            if (bus.pwr_req) begin
              ret    <= 1'b1;
              psw_en <= 1'b0;
            end
          end
        end
        ST_OFF_WAIT: if (bus.pwr && (cnt == TO_LAST)) err <= 1'b1;
        ST_OFF:      if (!bus.pwr_req) psw_en <= 1'b1;
        ST_ON_WAIT:  if (!bus.pwr && (cnt == TO_LAST)) err <= 1'b1;
        ST_RESTORE:  ret <= 1'b0;
        ST_ISO_OFF:  iso <= 1'b0;
        ST_LOST:     if (!bus.pwr_req || bus.pwr) psw_en <= 1'b1;
        default:     ;
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    upf_ret_chan #(
      .WIDTH       (WIDTH),
      .CORRUPT_VAL (CORRUPT_VAL)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_en[c]),
      .save    (save_en[c]),
      .restore (restore_all),
      .corrupt (corrupt_all),
      .d       (bus.d[c*WIDTH +: WIDTH]),
      .main    (main_q[c])
    );
    assign bus.q[c*WIDTH +: WIDTH] = iso ? {WIDTH{ISO_VAL}} : main_q[c];
  end

  assign bus.psw_en    = psw_en;
  assign bus.iso       = iso;
  assign bus.ret       = ret;
  assign bus.busy      = (state != ST_ON);
  assign bus.ret_valid = ret_valid;
  assign bus.err       = err;

endmodule
